// File: rtl/cpu_failover_ctrl.sv
// Dual-CPU A/B failover controller: synchronises and debounces the CPU
// health lines, keeps saturating fault counts, picks a target CPU and only
// moves the registered `switch` select once the outgoing CPU's TX line has
// gone idle (or a drain timeout expires).
module cpu_failover_ctrl #(
  parameter int DEB_CYC   = 16,
  parameter int IDLE_CYC  = 2000,
  parameter int DWELL_CYC = 100000,
  parameter int MAX_DRAIN = 8000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_a,
  input  logic             io_b,
  input  logic             force_swi,
  input  logic             com_swi,
  input  logic             srx_cpuA,
  input  logic             srx_cpuB,
  output logic             switch,
  output logic             busy,
  output logic [CNT_W-1:0] a_err_num,
  output logic [CNT_W-1:0] b_err_num,
  output logic [1:0]       state
);

  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int IDLE_W  = $clog2(IDLE_CYC + 1);
  localparam int DWELL_W = $clog2(DWELL_CYC + 1);
  localparam int DRAIN_W = $clog2(MAX_DRAIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bit 1 of the code is the selected side, bit 0 marks a drain state.
  typedef enum logic [1:0] {
    ACT_A    = 2'd0,
    DRAIN_AB = 2'd1,
    ACT_B    = 2'd2,
    DRAIN_BA = 2'd3
  } st_t;

  // Sync bit order: {com, force, srxB, srxA, io_b, io_a}; idle/healthy reset values.
  localparam logic [5:0] SYNC_RST = 6'b00_1111;

  logic [5:0] s1_q, s2_q;
  logic [1:0] hlt_s, srx_s;
  logic       frc_s, com_s, frc_prev_q, frc_rise;

  logic [1:0]            flt_q, flt_d;
  logic [1:0][DEB_W-1:0] deb_q, deb_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  st_t               state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               switch_q, busy_q;
  logic               side, tgt;

  // Two-flop synchroniser for every asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= SYNC_RST;
      s2_q <= SYNC_RST;
    end else begin
      s1_q <= {com_swi, force_swi, srx_cpuB, srx_cpuA, io_b, io_a};
      s2_q <= s1_q;
    end
  end

  assign hlt_s    = s2_q[1:0];
  assign srx_s    = s2_q[3:2];
  assign frc_s    = s2_q[4];
  assign com_s    = s2_q[5];
  assign frc_rise = frc_s & ~frc_prev_q;

  // Debounce: a run of DEB_CYC samples disagreeing with the held fault flips it.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flt_d[i] = flt_q[i];
      deb_d[i] = '0;
      if (hlt_s[i] == flt_q[i]) begin
        if (deb_q[i] == DEB_W'(DEB_CYC - 1)) flt_d[i] = ~flt_q[i];
        else                                 deb_d[i] = deb_q[i] + 1'b1;
      end
    end
  end

  // Saturating fault counts; a force rising edge clears them and wins over an increment.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (frc_rise)                                    cnt_d[i] = '0;
      else if (flt_d[i] & ~flt_q[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  // Conditioning state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_q      <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      frc_prev_q <= 1'b0;
    end else begin
      flt_q      <= flt_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      frc_prev_q <= frc_s;
    end
  end

  assign side = state_q[1];

  // Target side in priority order: faults, force, counts, otherwise stay.
  always_comb begin
    tgt = side;
    if (flt_q[0] & ~flt_q[1])      tgt = 1'b1;
    else if (flt_q[1] & ~flt_q[0]) tgt = 1'b0;
    else if (flt_q[0] & flt_q[1])  tgt = side;
    else if (frc_s)                tgt = com_s;
    else if (cnt_q[0] > cnt_q[1])  tgt = 1'b1;
    else if (cnt_q[0] < cnt_q[1])  tgt = 1'b0;
  end

  // Next state and timers; abort is tested first so it beats idle/timeout.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    idle_d  = '0;
    drain_d = '0;
    case (state_q)
      ACT_A, ACT_B: begin
        if (dwell_q < DWELL_W'(DWELL_CYC)) dwell_d = dwell_q + 1'b1;
        if (tgt != side && (flt_q[side] || dwell_q >= DWELL_W'(DWELL_CYC)))
          state_d = (side) ? DRAIN_BA : DRAIN_AB;
      end
      default: begin
        idle_d  = srx_s[side] ? idle_q + 1'b1 : '0;
        drain_d = drain_q + 1'b1;
        if (tgt == side) begin
          state_d = (side) ? ACT_B : ACT_A;
          idle_d  = '0;
          drain_d = '0;
        end else if (idle_q == IDLE_W'(IDLE_CYC) || drain_q == DRAIN_W'(MAX_DRAIN)) begin
          state_d = (side) ? ACT_A : ACT_B;
          dwell_d = '0;
          idle_d  = '0;
          drain_d = '0;
        end
      end
    endcase
  end

  // FSM state, timers and the registered select/busy outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACT_A;
      dwell_q  <= '0;
      idle_q   <= '0;
      drain_q  <= '0;
      switch_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      idle_q   <= idle_d;
      drain_q  <= drain_d;
      switch_q <= state_d[1];
      busy_q   <= state_d[0];
    end
  end

  assign switch    = switch_q;
  assign busy      = busy_q;
  assign a_err_num = cnt_q[0];
  assign b_err_num = cnt_q[1];
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_failover_ctrl.sv
// Directed bench for cpu_failover_ctrl with small timing parameters.
module tb_cpu_failover_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, io_a, io_b, force_swi, com_swi, srx_cpuA, srx_cpuB;
  logic       switch, busy;
  logic [7:0] a_err_num, b_err_num;
  logic [1:0] state;
  int         checks = 0;
  int         errors = 0;

  cpu_failover_ctrl #(
    .DEB_CYC(4), .IDLE_CYC(8), .DWELL_CYC(32), .MAX_DRAIN(64), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_a(io_a), .io_b(io_b),
    .force_swi(force_swi), .com_swi(com_swi),
    .srx_cpuA(srx_cpuA), .srx_cpuB(srx_cpuB),
    .switch(switch), .busy(busy),
    .a_err_num(a_err_num), .b_err_num(b_err_num), .state(state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    io_a = 1; io_b = 1; force_swi = 0; com_swi = 0; srx_cpuA = 1; srx_cpuB = 1;

    // 1. reset
    do_reset();
    chk("rst_switch", switch, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_err", a_err_num, 0);
    chk("rst_b_err", b_err_num, 0);

    // 2. fault failover inside dwell
    step(5);
    io_a = 0;
    step(6);
    chk("flt_a_err", a_err_num, 1);
    chk("flt_state_pre", state, 0);
    step(1);
    chk("flt_state_drain", state, 1);
    chk("flt_busy", busy, 1);
    chk("flt_switch_hold", switch, 0);
    step(3);
    io_a = 1;
    step(5);
    chk("flt_switch_8", switch, 0);
    chk("flt_state_8", state, 1);
    step(1);
    chk("flt_switch_9", switch, 1);
    chk("flt_state_9", state, 2);
    chk("flt_busy_9", busy, 0);

    // 3a. glitch on io_b is filtered
    io_b = 0;
    step(3);
    io_b = 1;
    step(10);
    chk("glitch_b_err", b_err_num, 0);
    chk("glitch_state", state, 2);

    // 3b. forced changeover held off by TX activity
    do_reset();
    step(40);
    force_swi = 1; com_swi = 1; srx_cpuA = 0;
    step(5);
    chk("drn_state", state, 1);
    chk("drn_busy", busy, 1);
    chk("drn_switch", switch, 0);
    srx_cpuA = 1; step(5);
    srx_cpuA = 0; step(5);
    srx_cpuA = 1; step(5);
    srx_cpuA = 0; step(5);
    chk("drn_switch_act", switch, 0);
    srx_cpuA = 1;             // last rising edge; synced 2 edges later
    step(5);
    chk("drn_busy_idle", busy, 1);
    step(5);
    chk("drn_switch_10", switch, 0);
    step(1);
    chk("drn_switch_11", switch, 1);
    chk("drn_state_end", state, 2);
    chk("drn_busy_end", busy, 0);

    // 4. drain timeout with a continuously busy line
    force_swi = 0;
    do_reset();
    step(40);
    force_swi = 1; com_swi = 1; srx_cpuA = 0;
    for (int i = 1; i <= 68; i++) begin
      step(1);
      if (i == 3)  chk("to_state_drain", state, 1);
      if (i == 67) begin
        chk("to_switch_63", switch, 0);
        chk("to_busy_63", busy, 1);
      end
      if (i % 3 == 0) srx_cpuA = ~srx_cpuA;
    end
    chk("to_switch_64", switch, 1);
    chk("to_state_end", state, 2);

    // 5. abort by dropping force with equal counts
    force_swi = 0; srx_cpuA = 0;
    do_reset();
    step(40);
    force_swi = 1; com_swi = 1;
    step(5);
    chk("ab_state_drain", state, 1);
    force_swi = 0;
    step(2);
    chk("ab_state_hold", state, 1);
    step(1);
    chk("ab_state", state, 0);
    chk("ab_busy", busy, 0);
    chk("ab_switch", switch, 0);
    step(10);
    chk("ab_state_late", state, 0);
    chk("ab_switch_late", switch, 0);
    force_swi = 1;            // dwell kept across abort: drains at once
    step(3);
    chk("ab_redrain", state, 1);
    force_swi = 0;
    step(3);
    chk("ab_reabort", state, 0);
    srx_cpuA = 1;

    // 6. saturation, then clear on force rising edge
    do_reset();
    io_b = 0;
    step(10);
    chk("sat_b_err", b_err_num, 1);
    for (int p = 1; p <= 300; p++) begin
      io_a = 0; step(7);
      io_a = 1; step(7);
      if (p == 10) chk("sat_a_10", a_err_num, 10);
    end
    chk("sat_a_255", a_err_num, 255);
    chk("sat_b_hold", b_err_num, 1);
    chk("sat_state", state, 0);
    force_swi = 1; com_swi = 0;
    step(2);
    chk("clr_a_pre", a_err_num, 255);
    step(1);
    chk("clr_a", a_err_num, 0);
    chk("clr_b", b_err_num, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
